// File: rtl/hazard_pkg.sv
// Shared encodings for the pipeline hazard controller: writeback sources,
// forwarding select codes, multiply-tracker states and register-match helpers.
package hazard_pkg;

  localparam logic [2:0] WB_ALU = 3'b000;
  localparam logic [2:0] WB_MEM = 3'b001;
  localparam logic [2:0] WB_PC8 = 3'b010;

  // Execute-stage forwarding selects
  localparam logic [1:0] FWD_REG = 2'b00;
  localparam logic [1:0] FWD_W   = 2'b01;
  localparam logic [1:0] FWD_M   = 2'b10;

  // Decode-stage selects use the opposite encoding for M and W
  localparam logic [1:0] FWDD_M = 2'b01;
  localparam logic [1:0] FWDD_W = 2'b10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    ERR  = 2'd2
  } mult_state_e;

  // $0 is hardwired to zero, so it never produces a dependency
  function automatic logic reg_match(input logic [4:0] src, input logic [4:0] dst);
    return (src != 5'd0) && (src == dst);
  endfunction

  function automatic logic [1:0] fwd_exec(input logic [4:0] src,
                                          input logic rw_m, input logic [4:0] wr_m,
                                          input logic rw_w, input logic [4:0] wr_w);
    if (rw_m && reg_match(src, wr_m))      return FWD_M;
    else if (rw_w && reg_match(src, wr_w)) return FWD_W;
    else                                   return FWD_REG;
  endfunction

  // A load in Memory has no data yet, so it cannot feed the Decode comparator
  function automatic logic [1:0] fwd_dec(input logic [4:0] src,
                                         input logic rw_m, input logic [4:0] wr_m,
                                         input logic [2:0] wb_m,
                                         input logic rw_w, input logic [4:0] wr_w);
    if (rw_m && reg_match(src, wr_m) && (wb_m != WB_MEM)) return FWDD_M;
    else if (rw_w && reg_match(src, wr_w))                return FWDD_W;
    else                                                  return FWD_REG;
  endfunction

endpackage

// File: rtl/hazard_if.sv
// Hazard interface between the pipelined datapath (master) and the hazard unit (slave).
interface hazard_if;
  // No handshake: every signal is a level, valid in the cycle it is presented;
  // stall/flush/forward outputs are combinational answers for that same cycle.
  logic [4:0] rsD, rtD, rsE, rtE;
  logic [4:0] WriteRegE, WriteRegM, WriteRegW;
  logic [1:0] branchD;
  logic       multReadD;
  logic       RegWriteE, RegWriteM, RegWriteW;
  logic [2:0] WBSrcE, WBSrcM;
  logic       MultStartE, MultDoneE;
  logic       stallF, stallD, flushE;
  logic [1:0] forwardAD, forwardBD, forwardAE, forwardBE;
  logic       multBusy, multErr;

  modport master (
    output rsD, rtD, rsE, rtE, WriteRegE, WriteRegM, WriteRegW, branchD, multReadD,
           RegWriteE, RegWriteM, RegWriteW, WBSrcE, WBSrcM, MultStartE, MultDoneE,
    input  stallF, stallD, flushE, forwardAD, forwardBD, forwardAE, forwardBE,
           multBusy, multErr
  );

  modport slave (
    input  rsD, rtD, rsE, rtE, WriteRegE, WriteRegM, WriteRegW, branchD, multReadD,
           RegWriteE, RegWriteM, RegWriteW, WBSrcE, WBSrcM, MultStartE, MultDoneE,
    output stallF, stallD, flushE, forwardAD, forwardBD, forwardAE, forwardBE,
           multBusy, multErr
  );
endinterface

// File: rtl/mult_tracker.sv
// Tracks an in-flight multi-cycle multiply; a watchdog drops back to IDLE via ERR
// if MultDoneE never arrives, leaving a sticky error flag.
module mult_tracker
  import hazard_pkg::*;
#(
  parameter int MULT_TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_i,
  input  logic        done_i,
  output logic        busy_o,
  output logic        err_o,
  output mult_state_e state_o
);

  localparam logic [7:0] LAST_CNT = 8'(MULT_TIMEOUT - 1);

  mult_state_e state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        err_q, err_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 8'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    unique case (state_q)
      IDLE: begin
        cnt_d = 8'd0;
        if (start_i && !done_i) state_d = BUSY;
      end
      BUSY: begin
        // Done wins over a restart; a restart wins over the timeout
        if (done_i) begin
          state_d = IDLE;
          cnt_d   = 8'd0;
        end else if (start_i) begin
          cnt_d = 8'd0;
        end else if (cnt_q == LAST_CNT) begin
          state_d = ERR;
          cnt_d   = 8'd0;
          err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      ERR: begin
        state_d = IDLE;
        cnt_d   = 8'd0;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 8'd0;
      end
    endcase
  end

  assign busy_o  = (state_q == BUSY);
  assign err_o   = err_q;
  assign state_o = state_q;

endmodule

// File: rtl/hazard_unit.sv
// Pipeline hazard controller: combinational forwarding and stall detection plus a
// multiply tracker. Define HAZARD_PERF_EN to add saturating stall-cause counters.
module hazard_unit
  import hazard_pkg::*;
#(
  parameter int MULT_TIMEOUT = 64,
  parameter int CNT_W        = 32
) (
  input  logic             clk,
  input  logic             rst,
  hazard_if.slave          hz,
`ifdef HAZARD_PERF_EN
  input  logic             perfClr,
  output logic [CNT_W-1:0] lwStallCnt,
  output logic [CNT_W-1:0] brStallCnt,
  output logic [CNT_W-1:0] multStallCnt,
`endif
  output mult_state_e      dbg_state_o
);

  logic lwstall, branchstall, multstall, stall;
  logic mult_busy, mult_err;

  mult_tracker #(.MULT_TIMEOUT(MULT_TIMEOUT)) u_mult (
    .clk     (clk),
    .rst     (rst),
    .start_i (hz.MultStartE),
    .done_i  (hz.MultDoneE),
    .busy_o  (mult_busy),
    .err_o   (mult_err),
    .state_o (dbg_state_o)
  );

  assign hz.forwardAE = fwd_exec(hz.rsE, hz.RegWriteM, hz.WriteRegM, hz.RegWriteW, hz.WriteRegW);
  assign hz.forwardBE = fwd_exec(hz.rtE, hz.RegWriteM, hz.WriteRegM, hz.RegWriteW, hz.WriteRegW);
  assign hz.forwardAD = fwd_dec(hz.rsD, hz.RegWriteM, hz.WriteRegM, hz.WBSrcM,
                                hz.RegWriteW, hz.WriteRegW);
  assign hz.forwardBD = fwd_dec(hz.rtD, hz.RegWriteM, hz.WriteRegM, hz.WBSrcM,
                                hz.RegWriteW, hz.WriteRegW);

  always_comb begin
    lwstall     = (hz.WBSrcE == WB_MEM) &&
                  (reg_match(hz.rtE, hz.rsD) || reg_match(hz.rtE, hz.rtD));
    // Branch compares in Decode, so an ALU result in E or a load in M is too late
    branchstall = (hz.branchD != 2'b00) &&
                  ((hz.RegWriteE &&
                    (reg_match(hz.rsD, hz.WriteRegE) || reg_match(hz.rtD, hz.WriteRegE))) ||
                   ((hz.WBSrcM == WB_MEM) &&
                    (reg_match(hz.rsD, hz.WriteRegM) || reg_match(hz.rtD, hz.WriteRegM))));
    multstall   = hz.multReadD && (mult_busy || hz.MultStartE);
    stall       = lwstall || branchstall || multstall;
  end

  assign hz.stallF   = stall;
  assign hz.stallD   = stall;
  assign hz.flushE   = stall;
  assign hz.multBusy = mult_busy;
  assign hz.multErr  = mult_err;

`ifdef HAZARD_PERF_EN
  logic [CNT_W-1:0] lw_cnt_q, lw_cnt_d;
  logic [CNT_W-1:0] br_cnt_q, br_cnt_d;
  logic [CNT_W-1:0] mul_cnt_q, mul_cnt_d;

  always_ff @(posedge clk) begin
    if (rst || perfClr) begin
      lw_cnt_q  <= '0;
      br_cnt_q  <= '0;
      mul_cnt_q <= '0;
    end else begin
      lw_cnt_q  <= lw_cnt_d;
      br_cnt_q  <= br_cnt_d;
      mul_cnt_q <= mul_cnt_d;
    end
  end

  // Counters hold at all-ones rather than wrapping
  always_comb begin
    lw_cnt_d  = lw_cnt_q;
    br_cnt_d  = br_cnt_q;
    mul_cnt_d = mul_cnt_q;
    if (lwstall && !(&lw_cnt_q))      lw_cnt_d  = lw_cnt_q + CNT_W'(1);
    if (branchstall && !(&br_cnt_q))  br_cnt_d  = br_cnt_q + CNT_W'(1);
    if (multstall && !(&mul_cnt_q))   mul_cnt_d = mul_cnt_q + CNT_W'(1);
  end

  assign lwStallCnt   = lw_cnt_q;
  assign brStallCnt   = br_cnt_q;
  assign multStallCnt = mul_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_unit.sv
// Bench for hazard_unit: table-driven combinational vectors, random vectors against a
// small reference model, and hand-written multiply / watchdog / reset sequences.
module tb_hazard_unit;
  import hazard_pkg::*;

  localparam int W = 13;

  typedef struct {
    logic [4:0] rsD, rtD, rsE, rtE, wrE, wrM, wrW;
    logic [1:0] brD;
    logic       rwE, rwM, rwW;
    logic [2:0] wbE, wbM;
    logic [W-1:0] exp;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  hazard_if hz ();
  hazard_if hw ();
  mult_state_e dbg_a, dbg_b;

`ifdef HAZARD_PERF_EN
  logic        perfClr;
  logic [31:0] lwc, brc, mc, lwc_b, brc_b, mc_b;
`endif

  hazard_unit #(.MULT_TIMEOUT(64)) dut (
    .clk          (clk),
    .rst          (rst),
    .hz           (hz),
`ifdef HAZARD_PERF_EN
    .perfClr      (perfClr),
    .lwStallCnt   (lwc),
    .brStallCnt   (brc),
    .multStallCnt (mc),
`endif
    .dbg_state_o  (dbg_a)
  );

  hazard_unit #(.MULT_TIMEOUT(4)) dut_wd (
    .clk          (clk),
    .rst          (rst),
    .hz           (hw),
`ifdef HAZARD_PERF_EN
    .perfClr      (perfClr),
    .lwStallCnt   (lwc_b),
    .brStallCnt   (brc_b),
    .multStallCnt (mc_b),
`endif
    .dbg_state_o  (dbg_b)
  );

  // Watchdog instance only sees the multiply signals
  assign hw.rsD = 5'd0;  assign hw.rtD = 5'd0;
  assign hw.rsE = 5'd0;  assign hw.rtE = 5'd0;
  assign hw.WriteRegE = 5'd0; assign hw.WriteRegM = 5'd0; assign hw.WriteRegW = 5'd0;
  assign hw.branchD = 2'b00;
  assign hw.RegWriteE = 1'b0; assign hw.RegWriteM = 1'b0; assign hw.RegWriteW = 1'b0;
  assign hw.WBSrcE = WB_ALU; assign hw.WBSrcM = WB_ALU;
  assign hw.multReadD  = hz.multReadD;
  assign hw.MultStartE = hz.MultStartE;
  assign hw.MultDoneE  = hz.MultDoneE;

  logic [W-1:0] exp_q[$];
  int n_chk = 0;
  int n_err = 0;
  vec_t tbl[17];

  function automatic logic [W-1:0] mk(input logic s, input logic [1:0] fad, input logic [1:0] fbd,
                                      input logic [1:0] fae, input logic [1:0] fbe,
                                      input logic b, input logic e);
    return {s, s, s, fad, fbd, fae, fbe, b, e};
  endfunction

  function automatic vec_t mv(input logic [4:0] rsD, rtD, rsE, rtE, wrE, wrM, wrW,
                              input logic [1:0] brD, input logic rwE, rwM, rwW,
                              input logic [2:0] wbE, wbM, input logic [W-1:0] e);
    vec_t v;
    v.rsD = rsD; v.rtD = rtD; v.rsE = rsE; v.rtE = rtE;
    v.wrE = wrE; v.wrM = wrM; v.wrW = wrW; v.brD = brD;
    v.rwE = rwE; v.rwM = rwM; v.rwW = rwW; v.wbE = wbE; v.wbM = wbM; v.exp = e;
    return v;
  endfunction

  // Reference model for the combinational outputs with no multiply in flight
  function automatic logic [W-1:0] model(input vec_t v);
    logic [1:0] fae, fbe, fad, fbd;
    logic lw, br, hitE, hitM;
    fae = (v.rwM && v.rsE != 0 && v.rsE == v.wrM) ? 2'b10 :
          (v.rwW && v.rsE != 0 && v.rsE == v.wrW) ? 2'b01 : 2'b00;
    fbe = (v.rwM && v.rtE != 0 && v.rtE == v.wrM) ? 2'b10 :
          (v.rwW && v.rtE != 0 && v.rtE == v.wrW) ? 2'b01 : 2'b00;
    fad = (v.rwM && v.rsD != 0 && v.rsD == v.wrM && v.wbM != 3'b001) ? 2'b01 :
          (v.rwW && v.rsD != 0 && v.rsD == v.wrW) ? 2'b10 : 2'b00;
    fbd = (v.rwM && v.rtD != 0 && v.rtD == v.wrM && v.wbM != 3'b001) ? 2'b01 :
          (v.rwW && v.rtD != 0 && v.rtD == v.wrW) ? 2'b10 : 2'b00;
    lw   = (v.wbE == 3'b001) && (v.rtE != 0) && (v.rtE == v.rsD || v.rtE == v.rtD);
    hitE = v.rwE && (v.wrE != 0) && (v.wrE == v.rsD || v.wrE == v.rtD);
    hitM = (v.wbM == 3'b001) && (v.wrM != 0) && (v.wrM == v.rsD || v.wrM == v.rtD);
    br   = (v.brD != 0) && (hitE || hitM);
    return mk(lw || br, fad, fbd, fae, fbe, 1'b0, 1'b0);
  endfunction

  function automatic logic [W-1:0] actual(input bit wd);
    if (wd)
      return {hw.stallF, hw.stallD, hw.flushE, hw.forwardAD, hw.forwardBD,
              hw.forwardAE, hw.forwardBE, hw.multBusy, hw.multErr};
    return {hz.stallF, hz.stallD, hz.flushE, hz.forwardAD, hz.forwardBD,
            hz.forwardAE, hz.forwardBE, hz.multBusy, hz.multErr};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_in();
    hz.rsD = 0; hz.rtD = 0; hz.rsE = 0; hz.rtE = 0;
    hz.WriteRegE = 0; hz.WriteRegM = 0; hz.WriteRegW = 0;
    hz.branchD = 0; hz.multReadD = 0;
    hz.RegWriteE = 0; hz.RegWriteM = 0; hz.RegWriteW = 0;
    hz.WBSrcE = WB_ALU; hz.WBSrcM = WB_ALU;
    hz.MultStartE = 0; hz.MultDoneE = 0;
  endtask

  task automatic drive_vec(input vec_t v);
    hz.rsD = v.rsD; hz.rtD = v.rtD; hz.rsE = v.rsE; hz.rtE = v.rtE;
    hz.WriteRegE = v.wrE; hz.WriteRegM = v.wrM; hz.WriteRegW = v.wrW;
    hz.branchD = v.brD;
    hz.RegWriteE = v.rwE; hz.RegWriteM = v.rwM; hz.RegWriteW = v.rwW;
    hz.WBSrcE = v.wbE; hz.WBSrcM = v.wbM;
  endtask

  task automatic check(input string nm, input bit wd);
    logic [W-1:0] e, a;
    a = actual(wd);
    n_chk++;
    if (exp_q.size() == 0) begin
      n_err++;
      $display("FAIL %s: no expected value queued, got %b", nm, a);
    end else begin
      e = exp_q.pop_front();
      if (a !== e) begin
        n_err++;
        $display("FAIL %s: got %b expected %b (stallF,stallD,flushE,fAD,fBD,fAE,fBE,busy,err)",
                 nm, a, e);
      end
    end
  endtask

  task automatic check_val(input string nm, input logic [31:0] a, input logic [31:0] e);
    n_chk++;
    if (a !== e) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", nm, a, e);
    end
  endtask

  // One cycle of multiply-related stimulus, checked at the following negedge
  task automatic mstep(input logic st, input logic dn, input logic rd,
                       input logic [W-1:0] e, input string nm, input bit wd);
    tick();
    hz.MultStartE = st; hz.MultDoneE = dn; hz.multReadD = rd;
    exp_q.push_back(e);
    @(negedge clk);
    check(nm, wd);
  endtask

  initial begin
    vec_t v;
    rst = 1'b1;
`ifdef HAZARD_PERF_EN
    perfClr = 1'b0;
`endif
    clear_in();

    tbl[0]  = mv(0, 0, 5, 0, 0, 5, 5, 0, 0, 1, 1, WB_ALU, WB_ALU, mk(0, 2'b00, 2'b00, 2'b10, 2'b00, 0, 0));
    tbl[1]  = mv(0, 0, 0, 0, 0, 5, 5, 0, 0, 1, 1, WB_ALU, WB_ALU, mk(0, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0));
    tbl[2]  = mv(0, 0, 0, 7, 0, 0, 7, 0, 0, 0, 1, WB_ALU, WB_ALU, mk(0, 2'b00, 2'b00, 2'b00, 2'b01, 0, 0));
    tbl[3]  = mv(0, 0, 9, 0, 0, 9, 9, 0, 0, 0, 1, WB_ALU, WB_ALU, mk(0, 2'b00, 2'b00, 2'b01, 2'b00, 0, 0));
    tbl[4]  = mv(4, 4, 0, 0, 0, 4, 0, 0, 0, 1, 0, WB_ALU, WB_ALU, mk(0, 2'b01, 2'b01, 2'b00, 2'b00, 0, 0));
    tbl[5]  = mv(4, 0, 0, 0, 0, 4, 4, 0, 0, 1, 1, WB_ALU, WB_MEM, mk(0, 2'b10, 2'b00, 2'b00, 2'b00, 0, 0));
    tbl[6]  = mv(8, 0, 0, 8, 0, 0, 0, 0, 0, 0, 0, WB_MEM, WB_ALU, mk(1, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0));
    tbl[7]  = mv(8, 0, 0, 8, 0, 0, 0, 0, 0, 0, 0, WB_ALU, WB_ALU, mk(0, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0));
    tbl[8]  = mv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, WB_MEM, WB_ALU, mk(0, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0));
    tbl[9]  = mv(0, 12, 0, 12, 0, 0, 0, 0, 0, 0, 0, WB_MEM, WB_ALU, mk(1, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0));
    tbl[10] = mv(0, 3, 0, 0, 3, 0, 0, 1, 1, 0, 0, WB_ALU, WB_ALU, mk(1, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0));
    tbl[11] = mv(0, 3, 0, 0, 0, 3, 0, 1, 0, 1, 0, WB_ALU, WB_ALU, mk(0, 2'b00, 2'b01, 2'b00, 2'b00, 0, 0));
    tbl[12] = mv(6, 0, 0, 0, 0, 6, 0, 2, 0, 1, 0, WB_ALU, WB_MEM, mk(1, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0));
    tbl[13] = mv(0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, WB_ALU, WB_ALU, mk(0, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0));
    tbl[14] = mv(3, 0, 0, 0, 3, 0, 0, 0, 1, 0, 0, WB_ALU, WB_ALU, mk(0, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0));
    tbl[15] = mv(0, 5, 0, 0, 0, 5, 0, 3, 0, 1, 0, WB_ALU, WB_PC8, mk(0, 2'b00, 2'b01, 2'b00, 2'b00, 0, 0));
    tbl[16] = mv(2, 0, 2, 0, 0, 2, 2, 0, 0, 1, 1, WB_ALU, WB_ALU, mk(0, 2'b01, 2'b00, 2'b10, 2'b00, 0, 0));

    // Reset state
    tick();
    tick();
    exp_q.push_back(mk(0, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0));
    @(negedge clk);
    check("reset", 0);
    tick();
    rst = 1'b0;

    for (int i = 0; i < 17; i++) begin
      tick();
      drive_vec(tbl[i]);
      exp_q.push_back(tbl[i].exp);
      @(negedge clk);
      check($sformatf("vec%0d", i), 0);
    end

    for (int i = 0; i < 40; i++) begin
      v.rsD = 5'($urandom_range(0, 3)); v.rtD = 5'($urandom_range(0, 3));
      v.rsE = 5'($urandom_range(0, 3)); v.rtE = 5'($urandom_range(0, 3));
      v.wrE = 5'($urandom_range(0, 3)); v.wrM = 5'($urandom_range(0, 3));
      v.wrW = 5'($urandom_range(0, 3)); v.brD = 2'($urandom_range(0, 3));
      v.rwE = 1'($urandom_range(0, 1)); v.rwM = 1'($urandom_range(0, 1));
      v.rwW = 1'($urandom_range(0, 1));
      v.wbE = 3'($urandom_range(0, 2)); v.wbM = 3'($urandom_range(0, 2));
      v.exp = model(v);
      tick();
      drive_vec(v);
      exp_q.push_back(v.exp);
      @(negedge clk);
      check($sformatf("rand%0d", i), 0);
    end

    // Multiply: stall on the start cycle, busy until Done
    tick();
    clear_in();
    mstep(1, 0, 1, mk(1, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0), "mul_start", 0);
    for (int i = 1; i <= 4; i++)
      mstep(0, 0, 1, mk(1, 2'b00, 2'b00, 2'b00, 2'b00, 1, 0), $sformatf("mul_busy%0d", i), 0);
    mstep(0, 1, 1, mk(1, 2'b00, 2'b00, 2'b00, 2'b00, 1, 0), "mul_done", 0);
    mstep(0, 0, 1, mk(0, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0), "mul_after", 0);
    // Start and Done together never enter BUSY
    mstep(1, 1, 1, mk(1, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0), "mul_same_start", 0);
    mstep(0, 0, 1, mk(0, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0), "mul_same_after", 0);

    tick();
    clear_in();
    rst = 1'b1;
    tick();
    rst = 1'b0;

    // Watchdog on the MULT_TIMEOUT=4 instance
    mstep(1, 0, 1, mk(1, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0), "wd_start", 1);
    for (int i = 1; i <= 4; i++)
      mstep(0, 0, 1, mk(1, 2'b00, 2'b00, 2'b00, 2'b00, 1, 0), $sformatf("wd_busy%0d", i), 1);
    mstep(0, 0, 1, mk(0, 2'b00, 2'b00, 2'b00, 2'b00, 0, 1), "wd_err", 1);
    mstep(0, 0, 1, mk(0, 2'b00, 2'b00, 2'b00, 2'b00, 0, 1), "wd_sticky1", 1);
    mstep(0, 0, 0, mk(0, 2'b00, 2'b00, 2'b00, 2'b00, 0, 1), "wd_sticky2", 1);
    tick();
    clear_in();
    rst = 1'b1;
    exp_q.push_back(mk(0, 2'b00, 2'b00, 2'b00, 2'b00, 0, 1));
    @(negedge clk);
    check("wd_in_rst", 1);
    tick();
    rst = 1'b0;
    exp_q.push_back(mk(0, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0));
    @(negedge clk);
    check("wd_cleared", 1);

    // Reset during the second BUSY cycle
    mstep(1, 0, 1, mk(1, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0), "rb_start", 0);
    mstep(0, 0, 1, mk(1, 2'b00, 2'b00, 2'b00, 2'b00, 1, 0), "rb_busy1", 0);
    tick();
    rst = 1'b1;
    exp_q.push_back(mk(1, 2'b00, 2'b00, 2'b00, 2'b00, 1, 0));
    @(negedge clk);
    check("rb_busy2", 0);
`ifdef HAZARD_PERF_EN
    check_val("rb_cnt_before", mc, 32'd2);
`endif
    tick();
    rst = 1'b0;
    exp_q.push_back(mk(0, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0));
    @(negedge clk);
    check("rb_after", 0);
`ifdef HAZARD_PERF_EN
    check_val("rb_cnt_after", mc, 32'd0);
`endif

    check_val("sb_drained", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/hazard_unit.md
Name: hazard_unit

Overview:
- Pipeline hazard controller for the 5-stage MIPS core.
- It is the other end of the datapath's hazard interface: it consumes stage register numbers, RegWrite/WBSrc/branch/multiply status, and drives stallF, stallD, flushE and the forwarding selects.
- Forwarding and load-use/branch detection are combinational.
- Multiply tracking is a registered FSM with a timeout watchdog, so that mfhi/mflo in Decode waits for the multi-cycle multiplier.

Parameters:
- MULT_TIMEOUT, 64: cycles allowed in BUSY before the watchdog fires; 2..255.
- CNT_W, 32: width of the optional performance counters.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- rsD, rtD  in  5 each  Decode source registers.
- rsE, rtE  in  5 each  Execute source registers.
- WriteRegE, WriteRegM, WriteRegW  in  5 each  destination registers per stage.
- branchD  in  2  Decode branch type; nonzero means branch compare is in Decode.
- multReadD  in  1  Decode instruction reads the HI/LO multiply result.
- RegWriteE, RegWriteM, RegWriteW  in  1 each.
- WBSrcE, WBSrcM  in  3 each  writeback source select.
- MultStartE  in  1  multiply issued this cycle.
- MultDoneE  in  1  multiply result valid.
- stallF, stallD  out  1 each.
- flushE  out  1.
- forwardAD, forwardBD  out  2 each.
- forwardAE, forwardBE  out  2 each.
- multBusy  out  1  FSM in BUSY.
- multErr  out  1  sticky watchdog flag.

Behaviour:
- Reset (rst high at clk edge): FSM to IDLE; timeout counter 0; multErr 0. Combinational outputs then follow their equations, with multBusy 0.
- Register $0 never matches for forwarding or hazard detection.
- forwardAE / forwardBE, evaluated for rsE / rtE:
  - 2'b10 if RegWriteM and WriteRegM matches.
  - else 2'b01 if RegWriteW and WriteRegW matches.
  - else 2'b00.
  - M has priority over W.
- forwardAD / forwardBD, evaluated for rsD / rtD:
  - 2'b01 if RegWriteM and WriteRegM matches and WBSrcM != WB_MEM.
  - else 2'b10 if RegWriteW and WriteRegW matches.
  - else 2'b00.
- lwstall: WBSrcE == WB_MEM, and rtE is nonzero and equals rsD or rtD.
- branchstall: branchD != 0, and either of:
  - RegWriteE and WriteRegE (nonzero) matches rsD/rtD;
  - WBSrcM == WB_MEM and WriteRegM (nonzero) matches rsD/rtD.
- multstall: multReadD, and (state == BUSY or MultStartE).
- stallF = stallD = flushE = lwstall | branchstall | multstall. Combinational, same cycle.
- FSM states:
  - IDLE: go to BUSY on MultStartE && !MultDoneE. If Start and Done coincide, stay in IDLE.
  - BUSY: counter increments each cycle. Go to IDLE on MultDoneE (counter cleared). When counter reaches MULT_TIMEOUT-1 without Done, go to ERR.
  - ERR: multErr set and sticky until rst. Next cycle go to IDLE, which releases the stall (no deadlock).
  - A MultStartE arriving while in BUSY restarts the counter at 0.
- multBusy = (state == BUSY).
- rst mid-multiply: the FSM returns to IDLE and any stall it caused drops in the same cycle.

Optional Feature:
- Macro: HAZARD_PERF_EN.
- When defined, adds:
  - outputs lwStallCnt, brStallCnt, multStallCnt (CNT_W each);
  - input perfClr.
- Each counter increments on every cycle its stall cause is active (several can increment in the same cycle).
- Counters saturate at all-ones. They clear on rst or perfClr; perfClr has priority over increment.
- When not defined, these ports and registers are absent and the behaviour is otherwise identical.

Decomposition:
- Package hazard_pkg holds:
  - WBSrc encodings: WB_ALU=3'b000, WB_MEM=3'b001, WB_PC8=3'b010;
  - FWD_REG=2'b00, FWD_W=2'b01, FWD_M=2'b10 (Execute select codes);
  - FSM state typedef {IDLE, BUSY, ERR}.
- One sub-module, mult_tracker, holds the FSM, the watchdog counter and multErr. The forwarding and stall logic stays at top level.

Test Plan:
- Forwarding: rsE=5, RegWriteM=1, WriteRegM=5, RegWriteW=1, WriteRegW=5 -> forwardAE=2'b10. Same with rsE=0 -> 2'b00.
- Load-use: WBSrcE=WB_MEM, rtE=8, rsD=8 -> stallF=stallD=flushE=1 in the same cycle. Clear WBSrcE -> all 0.
- Branch: branchD=1, RegWriteE=1, WriteRegE=3, rtD=3 -> stall. Next cycle WriteRegM=3, WBSrcM=WB_ALU -> no stall, forwardBD=2'b01.
- Multiply: MultStartE pulse, multReadD=1 held -> stall 1 on the start cycle and multBusy=1 from the next cycle. MultDoneE after 5 cycles -> stall drops, multBusy=0.
- Watchdog: MULT_TIMEOUT=4, start with no Done -> ERR after 4 BUSY cycles, multErr=1 sticky, stall released the following cycle. rst -> multErr=0.
- Reset mid-BUSY: assert rst on busy cycle 2 -> multBusy=0 and stall=0 after the edge. With HAZARD_PERF_EN, multStallCnt=2 before the reset and 0 after.
